// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - operand memory, mac and result handshake bus of the dot-product sequencer
interface mac_seq_ctrl_if #(
    parameter int int_in_p   = 1,
    parameter int frac_in_p  = 11,
    parameter int int_out_p  = 10,
    parameter int frac_out_p = 22,
    parameter int max_len_p  = 1024
);
    localparam int in_w   = int_in_p + frac_in_p;
    localparam int out_w  = int_out_p + frac_out_p;
    localparam int addr_w = $clog2(max_len_p);

    // operand memories (A and B share the address)
    logic              rd_en_o;
    logic [addr_w-1:0] addr_o;
    logic [in_w-1:0]   a_data_i;
    logic [in_w-1:0]   b_data_i;

    // combinational mac
    logic [in_w-1:0]   mac_a_o;
    logic [in_w-1:0]   mac_b_o;
    logic [out_w-1:0]  mac_db_o;
    logic [out_w-1:0]  mac_data_i;

    // result handshake
    logic [out_w-1:0]  data_o;
    logic              valid_o;
    logic              ready_i;

    modport master (
        output rd_en_o, addr_o, mac_a_o, mac_b_o, mac_db_o, data_o, valid_o,
        input  a_data_i, b_data_i, mac_data_i, ready_i
    );

    modport slave (
        input  rd_en_o, addr_o, mac_a_o, mac_b_o, mac_db_o, data_o, valid_o,
        output a_data_i, b_data_i, mac_data_i, ready_i
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product sequencer driving an external combinational mac
module mac_seq_ctrl #(
    parameter int int_in_p   = 1,
    parameter int frac_in_p  = 11,
    parameter int int_out_p  = 10,
    parameter int frac_out_p = 22,
    parameter int max_len_p  = 1024,
    localparam int addr_w    = $clog2(max_len_p)
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    input  logic [addr_w:0] len_i,
    input  logic            abort_i,
    output logic            ready_o,
    output logic            busy_o,
    mac_seq_ctrl_if.master  bus
);
    localparam int out_w = int_out_p + frac_out_p;
    localparam logic [addr_w:0] max_len_c = (addr_w+1)'(max_len_p);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [out_w-1:0]  acc_r;
    logic [addr_w-1:0] cnt;
    logic [addr_w:0]   len_r;
    logic              rd_vld_r;
    logic              accept;
    logic              last_issue;

    // abort wins over a simultaneous start
    assign accept     = start_i && ready_o && !abort_i;
    assign last_issue = (state == RUN) && ({1'b0, cnt} == (len_r - 1'b1));

    // the mac is purely combinational: operands pass through, accumulator feeds back
    assign bus.mac_a_o  = bus.a_data_i;
    assign bus.mac_b_o  = bus.b_data_i;
    assign bus.mac_db_o = acc_r;
    assign bus.data_o   = acc_r;

    // state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        state_n     = state;
        ready_o     = 1'b0;
        busy_o      = 1'b0;
        bus.rd_en_o = 1'b0;
        bus.valid_o = 1'b0;
        bus.addr_o  = cnt;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (accept) begin
                    state_n = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o      = 1'b1;
                bus.rd_en_o = 1'b1;
                if (last_issue) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // no read issued; the final operand pair lands this cycle
                busy_o  = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                bus.valid_o = 1'b1;
                if (bus.ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort_i) begin
            state_n = IDLE;
        end
    end

    // address counter, length capture, read-valid pipe and accumulator
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_r    <= '0;
            cnt      <= '0;
            len_r    <= '0;
            rd_vld_r <= 1'b0;
        end else if (abort_i) begin
            // dropping rd_vld_r discards any operand pair still in flight
            acc_r    <= '0;
            cnt      <= '0;
            rd_vld_r <= 1'b0;
        end else begin
            rd_vld_r <= bus.rd_en_o;
            if (accept) begin
                len_r <= (len_i > max_len_c) ? max_len_c : len_i;
                cnt   <= '0;
                acc_r <= '0;
            end else begin
                if (rd_vld_r) begin
                    acc_r <= bus.mac_data_i;
                end
                if (state == RUN) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - table-driven and directed checks of mac_seq_ctrl
module tb_mac_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [10:0] len_i = '0;
    logic        abort_i = 1'b0;
    logic        ready_o;
    logic        busy_o;

    mac_seq_ctrl_if #(.int_in_p(1), .frac_in_p(11), .int_out_p(10), .frac_out_p(22), .max_len_p(1024)) bus ();

    mac_seq_ctrl #(.int_in_p(1), .frac_in_p(11), .int_out_p(10), .frac_out_p(22), .max_len_p(1024)) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .start_i  (start_i),
        .len_i    (len_i),
        .abort_i  (abort_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // operand memories with one-cycle registered read
    logic [11:0] mem_a [0:1023];
    logic [11:0] mem_b [0:1023];
    always @(posedge clk) begin
        if (bus.rd_en_o) begin
            bus.a_data_i <= mem_a[bus.addr_o];
            bus.b_data_i <= mem_b[bus.addr_o];
        end
    end

    // reference mac: Q1.11 * Q1.11 -> Q2.22, sign-extended to Q10.22, plus accumulator
    logic signed [23:0] prod;
    assign prod           = $signed(bus.mac_a_o) * $signed(bus.mac_b_o);
    assign bus.mac_data_i = {{8{prod[23]}}, prod} + bus.mac_db_o;

    typedef struct {
        logic [10:0] len;
        logic [11:0] a;
        logic [11:0] b;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_rd;
    } vec_t;

    vec_t vecs [9];
    int   n_cmp = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = a;
            mem_b[i] = b;
        end
    endtask

    // start a run from IDLE; returns cycles from accept to valid_o (-1 on timeout)
    task automatic run_op(input logic [10:0] l, output int lat, output int rd, output logic [31:0] res);
        int k;
        bus.ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        len_i   = l;
        @(negedge clk);
        start_i = 1'b0;
        lat = -1;
        rd  = 0;
        res = '0;
        k   = 1;
        while (k < 1200) begin
            if (bus.rd_en_o) rd++;
            if (bus.valid_o) begin
                lat = k;
                res = bus.data_o;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic finish_op();
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
    endtask

    initial begin
        int          lat;
        int          rd;
        logic [31:0] res;
        logic        seen;
        bus.ready_i = 1'b0;

        vecs[0] = '{11'd4,    12'h400, 12'h400, 32'h0040_0000, 6,    4};
        vecs[1] = '{11'd3,    12'h800, 12'h800, 32'h00C0_0000, 5,    3};
        vecs[2] = '{11'd3,    12'h400, 12'hC00, 32'hFFD0_0000, 5,    3};
        vecs[3] = '{11'd0,    12'h7FF, 12'h7FF, 32'h0000_0000, 1,    0};
        vecs[4] = '{11'd1,    12'h7FF, 12'h7FF, 32'h003F_F001, 3,    1};
        vecs[5] = '{11'd2,    12'h800, 12'h7FF, 32'hFF80_1000, 4,    2};
        vecs[6] = '{11'd600,  12'h800, 12'h800, 32'h9600_0000, 602,  600};
        vecs[7] = '{11'd1024, 12'h400, 12'h400, 32'h4000_0000, 1026, 1024};
        vecs[8] = '{11'd1029, 12'h400, 12'h400, 32'h4000_0000, 1026, 1024};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rd_en", 32'(bus.rd_en_o), 32'd0);
        check("rst_addr", 32'(bus.addr_o), 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        reset_ni = 1'b1;

        // table vectors
        for (int v = 0; v < 9; v++) begin
            fill(vecs[v].a, vecs[v].b);
            run_op(vecs[v].len, lat, rd, res);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_rd_cycles", v), 32'(rd), 32'(vecs[v].exp_rd));
            check($sformatf("v%0d_data", v), res, vecs[v].exp_data);
            finish_op();
            check($sformatf("v%0d_idle_after", v), {30'd0, ready_o, bus.valid_o}, 32'b10);
        end

        // DONE hold with start asserted and ready_i low
        fill(12'h400, 12'h400);
        run_op(11'd2, lat, rd, res);
        check("hold_data_first", res, 32'h0020_0000);
        start_i = 1'b1;
        len_i   = 11'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_data", i), bus.data_o, 32'h0020_0000);
            check($sformatf("hold%0d_flags", i), {29'd0, ready_o, bus.valid_o, bus.rd_en_o}, 32'b010);
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        bus.ready_i = 1'b0;
        check("hold_release_idle", {30'd0, ready_o, bus.valid_o}, 32'b10);
        @(negedge clk);
        check("hold_no_new_run", {30'd0, busy_o, bus.rd_en_o}, 32'b00);

        // abort at cnt=2 of len=8
        start_i = 1'b1;
        len_i   = 11'd8;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rd_en_o && bus.addr_o == 10'd2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_cnt2", 32'(seen), 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_idle", {29'd0, ready_o, busy_o, bus.rd_en_o}, 32'b100);
        check("abort_acc", bus.data_o, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        mem_a[0] = 12'h600;
        mem_b[0] = 12'h200;
        run_op(11'd1, lat, rd, res);
        check("post_abort_latency", 32'(lat), 32'd3);
        check("post_abort_data", res, 32'h000C_0000);
        finish_op();

        // asynchronous reset mid-RUN
        fill(12'h400, 12'h400);
        start_i = 1'b1;
        len_i   = 11'd8;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset_ni = 1'b0;
        #1;
        check("midrst_flags", {28'd0, ready_o, busy_o, bus.rd_en_o, bus.valid_o}, 32'b1000);
        check("midrst_addr", 32'(bus.addr_o), 32'd0);
        check("midrst_data", bus.data_o, 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        run_op(11'd2, lat, rd, res);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_data", res, 32'h0020_0000);
        finish_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
